pwm_sample_scheduler: RTL and testbench
=======================================

// Module: pwm_sample_scheduler
// PURPOSE
//  Paces PCM samples into the PWM audio output stage at one sample per PWM period.
//  Buffers upstream samples in a small FIFO with valid/ready handshake and primes
//  before playback. Handles underrun by outputting silence, and applies mute.
//  Sits between the audio source (DSP/decoder) and the PWM audio output block.
// PARAMETERS
//  SAMPLE_WIDTH       16  PCM sample width, signed two's complement
//  PWM_COUNTER_WIDTH  10  PWM counter width; sample period = 2**PWM_COUNTER_WIDTH clk
//  FIFO_DEPTH          8  FIFO entries, power of two, >=2
//  PRIME_LEVEL         4  FIFO level required to (re)start playback, 1..FIFO_DEPTH
// PORTS
//  clk             in   1                 system clock
//  rst             in   1                 synchronous reset, active-high
//  enable          in   1                 playback enable; 0 forces IDLE
//  mute            in   1                 mute request (level)
//  s_valid         in   1                 upstream sample valid
//  s_ready         out  1                 FIFO can accept (level < FIFO_DEPTH)
//  s_data          in   SAMPLE_WIDTH      upstream sample, signed
//  sample_out      out  SAMPLE_WIDTH      sample to PWM stage, signed, registered
//  sample_strobe   out  1                 1-cycle pulse when sample_out updates
//  fifo_level      out  clog2(DEPTH)+1    current FIFO occupancy
//  underrun_count  out  16                count of underrun events, saturating
//  state_o         out  2                 0=IDLE 1=PRIME 2=RUN 3=UNDERRUN
// BEHAVIOUR
//  Reset: sample_out=0, sample_strobe=0, fifo empty, s_ready=0 during rst then 1,
//   underrun_count=0, period counter=0, state=IDLE, mute attenuation=0.
//  Tick: period counter free-runs 0..2**PWM_COUNTER_WIDTH-1; tick=1 when ==max.
//   Reset together with PWM stage so sample updates align with PWM counter wrap.
//  Write: push when s_valid&&s_ready; s_ready combinational from level. Full -> no push.
//  FSM (evaluated every cycle, actions only on tick):
//   IDLE: enable=1 -> PRIME. FIFO still accepts writes. Output held 0.
//   PRIME: level>=PRIME_LEVEL -> RUN (transition any cycle); output 0 on ticks.
//   RUN: on tick pop head -> sample_out (after mute stage). If tick with level==0:
//    -> UNDERRUN, sample_out=0, underrun_count+1 (saturate at 16'hFFFF).
//   UNDERRUN: output 0 on ticks; level>=PRIME_LEVEL -> RUN.
//   enable=0 in any state -> IDLE next cycle; FIFO contents kept; sample_out=0 on next tick.
//  sample_strobe pulses on every tick (all states), same cycle sample_out updates.
//  Latency: sample pushed into empty FIFO in RUN appears at next tick (<= period).
//  Simultaneous push and pop same cycle: both occur; level unchanged; push at full
//   with pop same cycle is still refused (s_ready from pre-pop level).
//  Pointers wrap modulo FIFO_DEPTH; level is the only full/empty indicator.
//  rst mid-operation: all state cleared next edge, FIFO flushed, counters zeroed.
// CONFIGURATION
//  PWM_SOFT_MUTE_EN defined: attenuation shift a (0..SAMPLE_WIDTH) steps +1 per tick
//   while mute=1, -1 per tick while mute=0; sample_out = s >>> a; a==SAMPLE_WIDTH
//   forces 0. FIFO still popped in RUN while muted (stream keeps time).
//  PWM_SOFT_MUTE_EN undefined: mute=1 -> sample_out=0 from next tick; unmute immediate.
// TESTING (sim params PWM_COUNTER_WIDTH=4 -> period 16, FIFO_DEPTH=8, PRIME_LEVEL=4)
//  Prime: enable=1, push 3 samples -> PRIME, outputs 0; 4th push -> RUN; next tick
//   sample_out = 1st sample, strobe 1 cycle, then one sample per 16 cycles in order.
//  Full: push 9 with no pops (IDLE) -> s_ready=0 after 8, fifo_level=8, 9th refused.
//  Underrun: RUN, stop pushes -> after FIFO drains, next tick sample_out=0,
//   state=UNDERRUN, underrun_count=1; push 4 -> RUN again.
//  Disable/reset: enable=0 mid-RUN -> IDLE next cycle, sample_out=0 at next tick;
//   rst=1 one cycle -> fifo_level=0, underrun_count=0, state=IDLE.
//  Mute (macro off): stream 16'sh4000, mute=1 -> next tick 0; mute=0 -> 16'sh4000.
//  Mute (PWM_SOFT_MUTE_EN): stream 16'sh4000 -> ticks give 2000,1000,...,0 by 16th.

Source files
------------

// File: rtl/pwm_sample_scheduler.sv
// Paces buffered PCM samples into the PWM stage, one sample per PWM period, with priming,
// underrun silence and mute. Define PWM_SOFT_MUTE_EN for a stepped arithmetic-shift soft mute.
module pwm_sample_scheduler #(
    parameter int SAMPLE_WIDTH      = 16,
    parameter int PWM_COUNTER_WIDTH = 10,
    parameter int FIFO_DEPTH        = 8,
    parameter int PRIME_LEVEL       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          mute,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [SAMPLE_WIDTH-1:0]       s_data,
    output logic [SAMPLE_WIDTH-1:0]       sample_out,
    output logic                          sample_strobe,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underrun_count,
    output logic [1:0]                    state_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LEVEL);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PRIME    = 2'd1,
        S_RUN      = 2'd2,
        S_UNDERRUN = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [PWM_COUNTER_WIDTH-1:0]  cnt_q, cnt_d;
    logic [SAMPLE_WIDTH-1:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]                 level_q, level_d;
    logic [SAMPLE_WIDTH-1:0]       sample_q, sample_d;
    logic                          strobe_q, strobe_d;
    logic [15:0]                   ucnt_q, ucnt_d;
    logic                          tick, push, pop;
    logic [SAMPLE_WIDTH-1:0]       head, shaped;

    assign tick = (cnt_q == '1);
    assign head = mem_q[rd_ptr_q];
    // Readiness uses the pre-pop level, so a full FIFO refuses a push even while popping.
    assign s_ready = !rst && (level_q < DEPTH_L);
    assign push    = s_valid && s_ready;

`ifdef PWM_SOFT_MUTE_EN
    localparam int AT_W = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [AT_W-1:0] AT_MAX = AT_W'(SAMPLE_WIDTH);
    logic [AT_W-1:0] atten_q, atten_d;

    always_comb begin
        atten_d = atten_q;
        if (tick) begin
            if (mute) begin
                if (atten_q != AT_MAX) atten_d = atten_q + AT_W'(1);
            end else if (atten_q != '0) begin
                atten_d = atten_q - AT_W'(1);
            end
        end
        shaped = (atten_d == AT_MAX) ? '0 : SAMPLE_WIDTH'($signed(head) >>> atten_d);
    end

    always_ff @(posedge clk) begin
        if (rst) atten_q <= '0;
        else     atten_q <= atten_d;
    end
`else
    always_comb begin
        shaped = mute ? '0 : head;
    end
`endif

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        strobe_d = tick;
        ucnt_d   = ucnt_q;
        pop      = 1'b0;
        cnt_d    = cnt_q + PWM_COUNTER_WIDTH'(1);
        if (!enable) begin
            state_d = S_IDLE;
            if (tick) sample_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_PRIME;
                    if (tick) sample_d = '0;
                end
                S_PRIME, S_UNDERRUN: begin
                    if (level_q >= PRIME_L) state_d = S_RUN;
                    if (tick) sample_d = '0;
                end
                S_RUN: begin
                    if (tick) begin
                        if (level_q == '0) begin
                            state_d  = S_UNDERRUN;
                            sample_d = '0;
                            if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
                        end else begin
                            pop      = 1'b1;
                            sample_d = shaped;
                        end
                    end
                end
            endcase
        end
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sample_q <= '0;
            strobe_q <= 1'b0;
            ucnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sample_q <= sample_d;
            strobe_q <= strobe_d;
            ucnt_q   <= ucnt_d;
        end
    end

    assign sample_out     = sample_q;
    assign sample_strobe  = strobe_q;
    assign fifo_level     = level_q;
    assign underrun_count = ucnt_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Bench for pwm_sample_scheduler: directed phase table with hand-derived end values, then
// randomized traffic checked every cycle against a queue-based model of the scheduler.
module tb_pwm_sample_scheduler;
    localparam int SW    = 16;
    localparam int CW    = 4;
    localparam int DEPTH = 8;
    localparam int PRIME = 4;
    localparam int LW    = 4;
    localparam int PER   = 16;

    logic          clk = 1'b0;
    logic          rst, enable, mute, s_valid, s_ready;
    logic [SW-1:0] s_data, sample_out;
    logic          sample_strobe;
    logic [LW-1:0] fifo_level;
    logic [15:0]   underrun_count;
    logic [1:0]    state_o;

    always #5 clk = ~clk;

    pwm_sample_scheduler #(
        .SAMPLE_WIDTH(SW), .PWM_COUNTER_WIDTH(CW), .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PRIME)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mute(mute),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .sample_out(sample_out), .sample_strobe(sample_strobe), .fifo_level(fifo_level),
        .underrun_count(underrun_count), .state_o(state_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase within the PWM period, a sample queue, and the playback mode.
    int          m_phase = 0;
    int          m_state = 0;
    logic [15:0] m_q[$];
    logic [15:0] m_out = 0;
    logic        m_strobe = 0;
    logic [15:0] m_ucnt = 0;
    int          m_atten = 0;

    function automatic logic [15:0] shape(input logic [15:0] x, input logic m, input int a);
`ifdef PWM_SOFT_MUTE_EN
        logic signed [15:0] sx;
        sx = x;
        if (a >= SW) return 16'h0;
        return 16'(sx >>> a);
`else
        return m ? 16'h0 : x;
`endif
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic m, input logic v,
                              input logic [15:0] d);
        bit tick, acc, do_pop;
        int lvl;
        if (r) begin
            m_phase = 0; m_state = 0; m_q.delete(); m_out = 0; m_strobe = 0;
            m_ucnt = 0; m_atten = 0;
            return;
        end
        tick   = (m_phase == PER - 1);
        lvl    = m_q.size();
        acc    = v && (lvl < DEPTH);
        do_pop = 0;
        if (tick) m_atten = m ? ((m_atten < SW) ? m_atten + 1 : SW) : ((m_atten > 0) ? m_atten - 1 : 0);
        m_strobe = tick;
        if (!e) begin
            m_state = 0;
            if (tick) m_out = 0;
        end else if (m_state == 0) begin
            m_state = 1;
            if (tick) m_out = 0;
        end else if (m_state == 1 || m_state == 3) begin
            if (lvl >= PRIME) m_state = 2;
            if (tick) m_out = 0;
        end else if (tick) begin
            if (lvl == 0) begin
                m_state = 3;
                m_out = 0;
                if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 1;
            end else begin
                do_pop = 1;
                m_out = shape(m_q[0], m, m_atten);
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (acc) m_q.push_back(d);
        m_phase = (m_phase + 1) % PER;
    endtask

    task automatic do_cycle(input logic r, input logic e, input logic m, input logic v,
                            input logic [15:0] d);
        logic        exp_ready;
        logic [38:0] exp_v, act_v;
        rst = r; enable = e; mute = m; s_valid = v; s_data = d;
        #1;
        exp_ready = !r && (m_q.size() < DEPTH);
        n_vec++;
        if (s_ready !== exp_ready) begin
            n_err++;
            $display("FAIL s_ready t=%0t got %b want %b", $time, s_ready, exp_ready);
        end
        model_edge(r, e, m, v, d);
        @(posedge clk);
        #1;
        exp_v = {m_out, m_strobe, LW'(m_q.size()), m_ucnt, 2'(m_state)};
        act_v = {sample_out, sample_strobe, fifo_level, underrun_count, state_o};
        n_vec++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL model t=%0t got out=%h stb=%b lvl=%0d ucnt=%0d st=%0d want out=%h stb=%b lvl=%0d ucnt=%0d st=%0d",
                     $time, sample_out, sample_strobe, fifo_level, underrun_count, state_o,
                     m_out, m_strobe, m_q.size(), m_ucnt, m_state);
        end
    endtask

    typedef struct {
        logic        r, e, m, v;
        logic [15:0] d;
        int          n;
        logic [15:0] e_sample;
        logic        e_strobe;
        logic [3:0]  e_level;
        logic [15:0] e_ucnt;
        logic [1:0]  e_state;
        logic        e_ready;
    } row_t;

    function automatic row_t mk(input logic r, input logic e, input logic m, input logic v,
                                input logic [15:0] d, input int n, input logic [15:0] es,
                                input logic est, input logic [3:0] el, input logic [15:0] eu,
                                input logic [1:0] ess, input logic er);
        row_t x;
        x.r = r; x.e = e; x.m = m; x.v = v; x.d = d; x.n = n;
        x.e_sample = es; x.e_strobe = est; x.e_level = el; x.e_ucnt = eu;
        x.e_state = ess; x.e_ready = er;
        return x;
    endfunction

    row_t rows[18];

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rows[0]  = mk(1, 0, 0, 0, 16'h0000,  2, 16'h0000, 0, 0, 0, 0, 0); // reset
        rows[1]  = mk(0, 0, 0, 1, 16'h0100,  9, 16'h0000, 0, 8, 0, 0, 0); // fill in IDLE, 9th refused
        rows[2]  = mk(0, 1, 0, 0, 16'h0000,  1, 16'h0000, 0, 8, 0, 1, 0); // IDLE -> PRIME
        rows[3]  = mk(0, 1, 0, 0, 16'h0000,  1, 16'h0000, 0, 8, 0, 2, 0); // primed -> RUN
        rows[4]  = mk(0, 1, 0, 0, 16'h0000,  5, 16'h0100, 1, 7, 0, 2, 1); // first tick
        rows[5]  = mk(0, 1, 0, 0, 16'h0000,  1, 16'h0100, 0, 7, 0, 2, 1); // strobe one cycle
`ifdef PWM_SOFT_MUTE_EN
        rows[6]  = mk(0, 1, 1, 0, 16'h0000, 15, 16'h0080, 1, 6, 0, 2, 1);
`else
        rows[6]  = mk(0, 1, 1, 0, 16'h0000, 15, 16'h0000, 1, 6, 0, 2, 1); // muted tick
`endif
        rows[7]  = mk(0, 1, 0, 0, 16'h0000, 16, 16'h0102, 1, 5, 0, 2, 1); // unmuted
        rows[8]  = mk(0, 1, 0, 0, 16'h0000, 80, 16'h0107, 1, 0, 0, 2, 1); // drained
        rows[9]  = mk(0, 1, 0, 0, 16'h0000, 16, 16'h0000, 1, 0, 1, 3, 1); // underrun
        rows[10] = mk(0, 1, 0, 1, 16'h0200,  3, 16'h0000, 0, 3, 1, 3, 1);
        rows[11] = mk(0, 1, 0, 1, 16'h0203,  1, 16'h0000, 0, 4, 1, 3, 1);
        rows[12] = mk(0, 1, 0, 0, 16'h0000,  1, 16'h0000, 0, 4, 1, 2, 1); // re-primed -> RUN
        rows[13] = mk(0, 1, 0, 0, 16'h0000, 11, 16'h0200, 1, 3, 1, 2, 1);
        rows[14] = mk(0, 0, 0, 0, 16'h0000,  1, 16'h0200, 0, 3, 1, 0, 1); // disable -> IDLE
        rows[15] = mk(0, 0, 0, 0, 16'h0000, 15, 16'h0000, 1, 3, 1, 0, 1); // silence at tick
        rows[16] = mk(1, 0, 0, 0, 16'h0000,  1, 16'h0000, 0, 0, 0, 0, 0); // mid-run reset
        rows[17] = mk(0, 0, 0, 0, 16'h0000,  1, 16'h0000, 0, 0, 0, 0, 1);

        rst = 1; enable = 0; mute = 0; s_valid = 0; s_data = 0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 18; k++) begin
            for (int i = 0; i < rows[k].n; i++)
                do_cycle(rows[k].r, rows[k].e, rows[k].m, rows[k].v, rows[k].d + 16'(i));
            n_vec++;
            if (sample_out !== rows[k].e_sample || sample_strobe !== rows[k].e_strobe ||
                fifo_level !== rows[k].e_level || underrun_count !== rows[k].e_ucnt ||
                state_o !== rows[k].e_state || s_ready !== rows[k].e_ready) begin
                n_err++;
                $display("FAIL row%0d got out=%h stb=%b lvl=%0d ucnt=%0d st=%0d rdy=%b want out=%h stb=%b lvl=%0d ucnt=%0d st=%0d rdy=%b",
                         k, sample_out, sample_strobe, fifo_level, underrun_count, state_o, s_ready,
                         rows[k].e_sample, rows[k].e_strobe, rows[k].e_level, rows[k].e_ucnt,
                         rows[k].e_state, rows[k].e_ready);
            end
        end

        // Random traffic: push density changes in bursts so the FIFO both fills and runs dry.
        begin
            int dens;
            dens = 10;
            for (int c = 0; c < 4000; c++) begin
                logic r, e, m, v;
                if (c % 200 == 0) begin
                    case ($urandom_range(0, 3))
                        0: dens = 2;
                        1: dens = 6;
                        2: dens = 10;
                        default: dens = 50;
                    endcase
                end
                r = ($urandom_range(0, 399) == 0);
                e = ($urandom_range(0, 29) != 0);
                m = ($urandom_range(0, 7) == 0);
                v = ($urandom_range(0, 99) < dens);
                do_cycle(r, e, m, v, 16'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
